seq_unpacker: RTL and testbench

Receive-side counterpart of the sequence packing logic. It accepts 8-bit packed words of the form {2 sign-extension bits, 2-bit AND field, 4-bit sequence field} over a valid/ready handshake. It checks that bits [7:6] are a correct sign extension of bit [5], and splits well-formed words back into their AND and sequence fields. Results are buffered in a small FIFO and presented downstream with their own valid/ready handshake. Malformed words are dropped and counted.

---
 rtl/seq_unpacker.sv | 118 +++++++++++
 tb/tb_seq_unpacker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_unpacker.sv
// -----------------------------------------------------------------------------
// seq_unpacker
//
// Receive-side unpacker for 8-bit packed words laid out as
//   [7:6] sign extension of bit 5, [5:4] AND field, [3:0] sequence field.
// Well-formed words are split into their fields and buffered in a small
// circular FIFO. Malformed words, whose top two bits do not replicate bit 5,
// are consumed and dropped. Each drop raises a one-cycle error pulse and bumps
// a saturating counter.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RST_n      asynchronous active-low reset
//   in_word    packed input word
//   in_valid   in_word is valid this cycle
//   in_ready   block can accept a word (FIFO not full, not in reset)
//   and_field  AND field of the FIFO head, 0 when out_valid is low
//   seq_field  sequence field of the FIFO head, 0 when out_valid is low
//   out_valid  FIFO head is valid
//   out_ready  downstream consumes the head this cycle
//   err_pulse  one-cycle pulse per dropped malformed word
//   err_cnt    saturating count of dropped malformed words
// -----------------------------------------------------------------------------
module seq_unpacker #(
   parameter int FIFO_DEPTH = 4,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic [7:0]           in_word,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [1:0]           and_field,
   output logic [3:0]           seq_field,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

   // Bits 7 and 6 must both replicate bit 5.
   function automatic logic is_well_formed(input logic [7:0] w);
      return (w[7] == w[5]) && (w[6] == w[5]);
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == '1) ? v : v + ERR_CNT_W'(1);
   endfunction

   logic [5:0]           mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [OCC_W-1:0]     occ;
   logic                 full;
   logic                 empty;
   logic                 accept_p0;
   logic                 good_p0;
   logic                 push_p0;
   logic                 drop_p0;
   logic                 pop_p0;
   logic                 err_vld_p1;
   logic [ERR_CNT_W-1:0] err_cnt_p1;
   logic [5:0]           head;

   // ---- stage p0: handshake decode and word classification ----
   assign full      = (occ == OCC_FULL);
   assign empty     = (occ == '0);
   // Ready comes from registered occupancy only; held low while in reset so
   // nothing presented during the reset cycle is taken.
   assign in_ready  = RST_n & ~full;
   assign accept_p0 = in_valid & in_ready;
   assign good_p0   = is_well_formed(in_word);
   assign push_p0   = accept_p0 & good_p0;
   assign drop_p0   = accept_p0 & ~good_p0;
   assign pop_p0    = ~empty & out_ready;

   // ---- stage p1: FIFO state and error tracking ----
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         err_vld_p1 <= 1'b0;
         err_cnt_p1 <= '0;
      end else begin
         // Pointers are exactly log2(depth) bits, so they wrap on their own.
         if (push_p0) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_p0)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_p0, pop_p0})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
         err_vld_p1 <= drop_p0;
         if (drop_p0) err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
   end

   // Storage is data only; stale entries are never visible because the
   // output fields are qualified by occupancy.
   always_ff @(posedge CLK) begin
      if (push_p0) mem[wr_ptr] <= in_word[5:0];
   end

   // ---- output decode from registered state ----
   assign head      = mem[rd_ptr];
   assign out_valid = ~empty;
   assign and_field = out_valid ? head[5:4] : 2'b00;
   assign seq_field = out_valid ? head[3:0] : 4'h0;
   assign err_pulse = err_vld_p1;
   assign err_cnt   = err_cnt_p1;

endmodule

// File: tb/tb_seq_unpacker.sv
module tb_seq_unpacker;

   logic       CLK;
   logic       RST_n;
   logic [7:0] in_word;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] and_field;
   logic [3:0] seq_field;
   logic       out_valid;
   logic       out_ready;
   logic       err_pulse;
   logic [1:0] err_cnt;

   int n_cmp = 0;
   int n_err = 0;

   seq_unpacker #(.FIFO_DEPTH(4), .ERR_CNT_W(2)) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .in_word   (in_word),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .and_field (and_field),
      .seq_field (seq_field),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   typedef struct {
      logic [7:0] word;
      logic       vld;
      logic       ordy;
      logic       exp_ir;
      logic       exp_ov;
      logic [1:0] exp_and;
      logic [3:0] exp_seq;
      logic       exp_ep;
      logic [1:0] exp_ec;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [7:0] mk_word(input int k);
      logic [1:0] a;
      logic [3:0] s;
      a = 2'(k);
      s = 4'(k * 3 + 1);
      return {{2{a[1]}}, a, s};
   endfunction

   logic [7:0] bp_w [5];
   logic [7:0] bad_w [5];
   logic [5:0] q [$];

   initial begin
      // cycle-by-cycle vectors: inputs held for the cycle, outputs observed in it
      tbl[0]  = '{8'hFA, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0};
      tbl[1]  = '{8'h15, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'hA, 1'b0, 2'd0};
      tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'h5, 1'b0, 2'd0};
      tbl[3]  = '{8'h3A, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0};
      tbl[4]  = '{8'hC5, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd1};
      tbl[5]  = '{8'h15, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2};
      tbl[6]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'h5, 1'b0, 2'd2};
      tbl[7]  = '{8'h9F, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd2};
      tbl[8]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd3};
      tbl[9]  = '{8'h5F, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd3};
      tbl[10] = '{8'h3A, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 2'd3};
      tbl[11] = '{8'hE0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd3};
      tbl[12] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'h0, 1'b0, 2'd3};
      tbl[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'h0, 1'b0, 2'd3};
      tbl[14] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 2'd3};
      tbl[15] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd3};

      bp_w[0] = 8'h01; bp_w[1] = 8'h12; bp_w[2] = 8'hE3; bp_w[3] = 8'hF4; bp_w[4] = 8'h05;
      bad_w[0] = 8'h3A; bad_w[1] = 8'hC5; bad_w[2] = 8'h9F; bad_w[3] = 8'h5F; bad_w[4] = 8'h7F;

      RST_n     = 1'b0;
      in_word   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // power-on reset
      @(posedge CLK);
      @(posedge CLK);
      #1;
      chk("rst_in_ready_low", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fields", {and_field, seq_field}, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_err_cnt", err_cnt, 0);
      @(negedge CLK);
      RST_n = 1'b1;
      #1;
      chk("rst_release_ready", in_ready, 1);
      next_cycle();

      // decode, drop, saturation and qualification vectors
      for (int i = 0; i < 16; i++) begin
         in_word   = tbl[i].word;
         in_valid  = tbl[i].vld;
         out_ready = tbl[i].ordy;
         @(negedge CLK);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_ir);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
         chk($sformatf("tbl%0d_fields", i), {and_field, seq_field}, {tbl[i].exp_and, tbl[i].exp_seq});
         chk($sformatf("tbl%0d_err_pulse", i), err_pulse, tbl[i].exp_ep);
         chk($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].exp_ec);
         next_cycle();
      end

      // reset mid-stream with three buffered words and a word on the input
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_word = 8'h15; next_cycle();
      in_word = 8'hFA; next_cycle();
      in_word = 8'hE0; next_cycle();
      in_valid = 1'b0;
      @(negedge CLK);
      chk("mid_prefill_valid", out_valid, 1);
      next_cycle();
      in_valid = 1'b1;
      in_word  = 8'h15;
      RST_n    = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_err_cnt", err_cnt, 0);
      chk("mid_rst_fields", {and_field, seq_field}, 0);
      @(negedge CLK);
      RST_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("mid_release_ready", in_ready, 1);
      chk("mid_release_valid", out_valid, 0);
      out_ready = 1'b1;
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk($sformatf("mid_no_stale%0d", i), out_valid, 0);
         next_cycle();
      end

      // back-to-back malformed words saturating a 2-bit counter
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            in_valid = 1'b1;
            in_word  = bad_w[i];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge CLK);
         chk($sformatf("sat%0d_pulse", i), err_pulse, (i == 0) ? 0 : 1);
         chk($sformatf("sat%0d_cnt", i), err_cnt, (i > 3) ? 3 : i);
         chk($sformatf("sat%0d_valid", i), out_valid, 0);
         next_cycle();
      end
      @(negedge CLK);
      chk("sat_pulse_end", err_pulse, 0);
      chk("sat_cnt_hold", err_cnt, 3);
      next_cycle();

      // fill to full with out_ready low, fifth word stalls
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_word = bp_w[i];
         @(negedge CLK);
         chk($sformatf("bp_ready%0d", i), in_ready, 1);
         next_cycle();
      end
      in_word = bp_w[4];
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         chk($sformatf("bp_full_ready%0d", i), in_ready, 0);
         chk($sformatf("bp_full_head%0d", i), {and_field, seq_field}, bp_w[0][5:0]);
         next_cycle();
      end
      out_ready = 1'b1;
      @(negedge CLK);
      chk("bp_pop0_ready", in_ready, 0);
      chk("bp_pop0_head", {and_field, seq_field}, bp_w[0][5:0]);
      next_cycle();
      @(negedge CLK);
      chk("bp_reassert_ready", in_ready, 1);
      chk("bp_pop1_head", {and_field, seq_field}, bp_w[1][5:0]);
      next_cycle();
      in_valid = 1'b0;
      for (int k = 2; k < 5; k++) begin
         @(negedge CLK);
         chk($sformatf("bp_drain_valid%0d", k), out_valid, 1);
         chk($sformatf("bp_drain_head%0d", k), {and_field, seq_field}, bp_w[k][5:0]);
         next_cycle();
      end
      @(negedge CLK);
      chk("bp_empty", out_valid, 0);
      next_cycle();

      // steady push/pop at occupancy 2, pointers wrap
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_word = mk_word(k);
         q.push_back(in_word[5:0]);
         next_cycle();
      end
      out_ready = 1'b1;
      for (int k = 2; k < 12; k++) begin
         in_word = mk_word(k);
         @(negedge CLK);
         chk($sformatf("ss%0d_valid", k), out_valid, 1);
         chk($sformatf("ss%0d_ready", k), in_ready, 1);
         chk($sformatf("ss%0d_head", k), {and_field, seq_field}, q[0]);
         void'(q.pop_front());
         q.push_back(in_word[5:0]);
         next_cycle();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         chk($sformatf("ss_drain%0d_head", k), {and_field, seq_field}, q[0]);
         void'(q.pop_front());
         next_cycle();
      end
      @(negedge CLK);
      chk("ss_empty", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
